// File: rtl/tb_host_ctrl_if.sv
// Request/response bus used on both sides of the host controller.
// master: drives r_v/w_v/adr/data/strobe, receives res/res_v/res_error.
// slave:  receives the request, drives the response.
interface tb_host_ctrl_if #(
   parameter int XLEN = 32
);
   logic            r_v;
   logic            w_v;
   logic [XLEN-1:0] adr;
   logic [XLEN-1:0] data;
   logic [3:0]      strobe;
   logic [XLEN-1:0] res;
   logic            res_v;
   logic            res_error;

   modport master (
      output r_v, w_v, adr, data, strobe,
      input  res, res_v, res_error
   );

   modport slave (
      input  r_v, w_v, adr, data, strobe,
      output res, res_v, res_error
   );
endinterface

// File: rtl/tb_host_ctrl.sv
// Host-interface controller on the data-memory bus: MMIO window (exit,
// console FIFO, cycle counter), memory forwarding, watchdog, MMIO latency.
// Ports: clk, rst_n (async, active low); cpu (slave side of the cpu bus);
//   mem (master side of the dmem bus); con_pop/con_char/con_v/con_ovf
//   console FIFO; exit_v/exit_code/timeout end-of-program status;
//   proto_err sticky flag for a request issued while one is outstanding.
module tb_host_ctrl #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] EXIT_ADR   = 'h0,
   parameter logic [XLEN-1:0] CON_ADR    = 'h4,
   parameter logic [XLEN-1:0] CYC_ADR    = 'h8,
   parameter int              MMIO_LAT   = 1,
   parameter int              TIMEOUT    = 1000000,
   parameter int              FIFO_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   tb_host_ctrl_if.slave   cpu,
   tb_host_ctrl_if.master  mem,
   input  logic            con_pop,
   output logic [7:0]      con_char,
   output logic            con_v,
   output logic            con_ovf,
   output logic            exit_v,
   output logic [XLEN-1:0] exit_code,
   output logic            timeout,
   output logic            proto_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [XLEN-1:0] ONE = XLEN'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MMIO,
      S_MEM
   } state_t;

   state_t          state_q;
   logic [XLEN-1:0] cyc_q;
   logic [XLEN-1:0] wd_q;
   logic [XLEN-1:0] exit_code_q;
   logic            exit_v_q;
   logic            timeout_q;
   logic            proto_q;
   logic            ovf_q;
   logic [AW-1:0]   wr_q;
   logic [AW-1:0]   rd_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;
   logic [7:0]      fifo_q [FIFO_DEPTH];

   // MMIO response pipe; stage MMIO_LAT-1 drives the cpu response.
   logic [MMIO_LAT-1:0] pv_q;
   logic [MMIO_LAT-1:0] pe_q;
   logic [XLEN-1:0]     pd_q [MMIO_LAT];

   logic            req_v;
   logic            both;
   logic            idle;
   logic            acc;
   logic            fwd;
   logic            macc;
   logic            sel_exit;
   logic            sel_con;
   logic            sel_cyc;
   logic            hit;
   logic [XLEN-1:0] rsp_d;
   logic            rsp_err_d;
   logic            full;
   logic            pop;
   logic            push;
   logic            do_push;
   logic            exit_wr;
   logic            wd_exp;
   logic            mmio_v;
   logic            pass;

   assign req_v = cpu.r_v | cpu.w_v;
   assign both  = cpu.r_v & cpu.w_v;
   assign idle  = (state_q == S_IDLE);
   assign acc   = req_v & idle;

   // Priority-masked so the selects stay one-hot.
   assign sel_exit = (cpu.adr == EXIT_ADR);
   assign sel_con  = (cpu.adr == CON_ADR) & ~sel_exit;
   assign sel_cyc  = (cpu.adr == CYC_ADR) & ~sel_exit & ~sel_con;
   assign hit      = sel_exit | sel_con | sel_cyc;

   // Only clean misses before exit reach memory; everything else is
   // answered from the MMIO pipe.
   assign fwd  = acc & ~hit & ~both & ~exit_v_q;
   assign macc = acc & ~fwd;

   always_comb begin
      rsp_d     = '0;
      rsp_err_d = 1'b0;
      if (exit_v_q || !hit) begin
         rsp_err_d = 1'b1;
      end else if (cpu.w_v) begin
         rsp_err_d = both | sel_cyc;
      end else begin
         unique case (1'b1)
            sel_exit: rsp_d = exit_code_q;
            sel_con:  rsp_d = XLEN'(cnt_q);
            sel_cyc:  rsp_d = cyc_q;
            default:  rsp_d = '0;
         endcase
      end
   end

   assign full    = (cnt_q == CW'(FIFO_DEPTH));
   assign pop     = con_pop & (cnt_q != '0);
   assign push    = macc & ~exit_v_q & cpu.w_v & sel_con & cpu.strobe[0];
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push & (~full | pop);
   assign cnt_d   = cnt_q + CW'(do_push) - CW'(pop);
   assign exit_wr = macc & ~exit_v_q & cpu.w_v & sel_exit & cpu.strobe[0];
   assign wd_exp  = (TIMEOUT != 0) && !exit_v_q
                    && (wd_q == XLEN'(TIMEOUT - 1));

   assign mmio_v = pv_q[MMIO_LAT-1];
   assign pass   = fwd | (state_q == S_MEM);

   assign mem.r_v    = fwd & cpu.r_v;
   assign mem.w_v    = fwd & cpu.w_v;
   assign mem.adr    = fwd ? cpu.adr : '0;
   assign mem.data   = fwd ? cpu.data : '0;
   assign mem.strobe = fwd ? cpu.strobe : '0;

   assign cpu.res_v     = mmio_v | (pass & mem.res_v);
   assign cpu.res       = pass ? mem.res : pd_q[MMIO_LAT-1];
   assign cpu.res_error = pass ? mem.res_error : pe_q[MMIO_LAT-1];

   assign con_v     = (cnt_q != '0);
   assign con_char  = con_v ? fifo_q[rd_q] : 8'h00;
   assign con_ovf   = ovf_q;
   assign exit_v    = exit_v_q;
   assign exit_code = exit_code_q;
   assign timeout   = timeout_q;
   assign proto_err = proto_q;

   always_ff @(posedge clk) begin
      if (do_push) begin
         fifo_q[wr_q] <= cpu.data[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cyc_q       <= '0;
         wd_q        <= '0;
         exit_code_q <= '0;
         exit_v_q    <= 1'b0;
         timeout_q   <= 1'b0;
         proto_q     <= 1'b0;
         ovf_q       <= 1'b0;
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         pv_q        <= '0;
         pe_q        <= '0;
         for (int i = 0; i < MMIO_LAT; i++) begin
            pd_q[i] <= '0;
         end
      end else begin
         cyc_q <= cyc_q + ONE;
         if (!exit_v_q) begin
            wd_q <= wd_q + ONE;
         end
         if (req_v && !idle) begin
            proto_q <= 1'b1;
         end
         if (push && full && !pop) begin
            ovf_q <= 1'b1;
         end
         cnt_q <= cnt_d;
         if (do_push) begin
            wr_q <= wr_q + AW'(1);
         end
         if (pop) begin
            rd_q <= rd_q + AW'(1);
         end
         // Exit write beats a watchdog expiry in the same cycle.
         if (exit_wr) begin
            exit_v_q    <= 1'b1;
            exit_code_q <= cpu.data;
         end else if (wd_exp) begin
            exit_v_q    <= 1'b1;
            timeout_q   <= 1'b1;
            exit_code_q <= '1;
         end
         pv_q[0] <= macc;
         pe_q[0] <= macc & rsp_err_d;
         pd_q[0] <= macc ? rsp_d : '0;
         for (int i = 1; i < MMIO_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pe_q[i] <= pe_q[i-1];
            pd_q[i] <= pd_q[i-1];
         end
         unique case (state_q)
            S_IDLE: begin
               if (fwd && !mem.res_v) begin
                  state_q <= S_MEM;
               end else if (macc) begin
                  state_q <= S_MMIO;
               end
            end
            S_MMIO: begin
               if (mmio_v) begin
                  state_q <= S_IDLE;
               end
            end
            S_MEM: begin
               if (mem.res_v) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tb_host_ctrl.sv
// Directed bench for tb_host_ctrl: a table of single MMIO transactions
// plus hand-written sequences for FIFO, forwarding, exit, latency, watchdog.
module tb_tb_host_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n;
   logic rst_b_n;

   tb_host_ctrl_if #(.XLEN(32)) cpu_a ();
   tb_host_ctrl_if #(.XLEN(32)) mem_a ();
   tb_host_ctrl_if #(.XLEN(32)) cpu_b ();
   tb_host_ctrl_if #(.XLEN(32)) mem_b ();

   logic        con_pop_a, con_v_a, con_ovf_a, exit_v_a, timeout_a, proto_a;
   logic        con_pop_b, con_v_b, con_ovf_b, exit_v_b, timeout_b, proto_b;
   logic [7:0]  con_char_a, con_char_b;
   logic [31:0] exit_code_a, exit_code_b;

   tb_host_ctrl #(
      .MMIO_LAT(1), .TIMEOUT(0), .FIFO_DEPTH(4)
   ) u_a (
      .clk(clk), .rst_n(rst_a_n), .cpu(cpu_a), .mem(mem_a),
      .con_pop(con_pop_a), .con_char(con_char_a), .con_v(con_v_a),
      .con_ovf(con_ovf_a), .exit_v(exit_v_a), .exit_code(exit_code_a),
      .timeout(timeout_a), .proto_err(proto_a)
   );

   tb_host_ctrl #(
      .MMIO_LAT(3), .TIMEOUT(50), .FIFO_DEPTH(16)
   ) u_b (
      .clk(clk), .rst_n(rst_b_n), .cpu(cpu_b), .mem(mem_b),
      .con_pop(con_pop_b), .con_char(con_char_b), .con_v(con_v_b),
      .con_ovf(con_ovf_b), .exit_v(exit_v_b), .exit_code(exit_code_b),
      .timeout(timeout_b), .proto_err(proto_b)
   );

   // Reference cycle counts: posedges seen since reset release.
   logic [31:0] bc_a, bc_b;
   always @(posedge clk or negedge rst_a_n)
      if (!rst_a_n) bc_a <= 0; else bc_a <= bc_a + 1;
   always @(posedge clk or negedge rst_b_n)
      if (!rst_b_n) bc_b <= 0; else bc_b <= bc_b + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk);
      #1;
   endtask

   task automatic pop_a;
      con_pop_a = 1'b1;
      nxt();
      con_pop_a = 1'b0;
   endtask

   task automatic clr_a;
      cpu_a.r_v = 0; cpu_a.w_v = 0; cpu_a.adr = 0;
      cpu_a.data = 0; cpu_a.strobe = 0;
   endtask

   // Called and returns at posedge+1; request held for one cycle.
   task automatic xact_a(input logic r, input logic w,
                         input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] stb, output logic [31:0] res,
                         output logic err, output int lat,
                         output logic fwd);
      res = '0; err = 1'b0; lat = -1;
      cpu_a.r_v = r; cpu_a.w_v = w; cpu_a.adr = adr;
      cpu_a.data = dat; cpu_a.strobe = stb;
      @(negedge clk);
      fwd = mem_a.r_v | mem_a.w_v;
      if (cpu_a.res_v) begin
         lat = 0; res = cpu_a.res; err = cpu_a.res_error;
      end
      nxt();
      clr_a();
      for (int i = 1; i <= 8 && lat < 0; i++) begin
         @(negedge clk);
         if (cpu_a.res_v) begin
            lat = i; res = cpu_a.res; err = cpu_a.res_error;
         end
         nxt();
      end
   endtask

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  stb;
      logic [31:0] res;
      logic        err;
   } vec_t;

   initial begin
      #200000;
      $display("FAIL global time limit");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t        tbl [12];
      logic [31:0] r;
      logic [31:0] expc;
      logic        e;
      logic        f;
      int          lat;
      int          g;
      int          seen;

      tbl[0]  = '{1'b0, 1'b1, 32'h4, 32'h41, 4'h1, 32'h0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 32'h4, 32'h142, 4'hf, 32'h0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h2, 1'b0};
      tbl[3]  = '{1'b0, 1'b1, 32'h4, 32'h99, 4'h0, 32'h0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h2, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 32'h8, 32'h5, 4'hf, 32'h0, 1'b1};
      tbl[6]  = '{1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 32'h0, 32'h55, 4'h0, 32'h0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 32'h30000, 32'h1, 4'hf, 32'h0, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 32'h4, 32'h43, 4'h1, 32'h0, 1'b1};
      tbl[11] = '{1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 32'h3, 1'b0};

      rst_a_n = 0; rst_b_n = 0;
      clr_a();
      con_pop_a = 0; con_pop_b = 0;
      cpu_b.r_v = 0; cpu_b.w_v = 0; cpu_b.adr = 0;
      cpu_b.data = 0; cpu_b.strobe = 0;
      mem_a.res = 0; mem_a.res_v = 0; mem_a.res_error = 0;
      mem_b.res = 0; mem_b.res_v = 0; mem_b.res_error = 0;

      repeat (2) nxt();
      @(negedge clk);
      chk("rst a flags", {cpu_a.res_v, cpu_a.res_error, mem_a.r_v,
          mem_a.w_v, con_v_a, con_ovf_a, exit_v_a, timeout_a, proto_a}, 0);
      chk("rst a bus", {cpu_a.res, mem_a.adr}, 0);
      chk("rst a misc", {exit_code_a, con_char_a, mem_a.strobe}, 0);
      chk("rst a data", mem_a.data, 0);
      chk("rst b flags", {cpu_b.res_v, exit_v_b, timeout_b, con_v_b,
          exit_code_b}, 0);
      nxt();
      rst_a_n = 1;
      nxt();

      for (int i = 0; i < 12; i++) begin
         xact_a(tbl[i].r, tbl[i].w, tbl[i].adr, tbl[i].dat, tbl[i].stb,
                r, e, lat, f);
         chk($sformatf("vec%0d res", i), r, tbl[i].res);
         chk($sformatf("vec%0d err", i), e, tbl[i].err);
         chk($sformatf("vec%0d lat", i), lat, 1);
         chk($sformatf("vec%0d fwd", i), f, 0);
      end

      @(negedge clk);
      chk("head 41", {con_v_a, con_char_a}, {1'b1, 8'h41});
      nxt();
      pop_a();
      @(negedge clk);
      chk("head 42", {con_v_a, con_char_a}, {1'b1, 8'h42});
      nxt();
      pop_a();
      @(negedge clk);
      chk("head 43", {con_v_a, con_char_a}, {1'b1, 8'h43});
      nxt();
      pop_a();
      @(negedge clk);
      chk("empty", {con_v_a, con_char_a}, 0);
      nxt();
      pop_a();
      xact_a(1, 0, 32'h4, 0, 0, r, e, lat, f);
      chk("cnt after empty pop", r, 0);

      for (int i = 0; i < 4; i++) begin
         xact_a(0, 1, 32'h4, 32'h61 + i, 4'h1, r, e, lat, f);
      end
      xact_a(1, 0, 32'h4, 0, 0, r, e, lat, f);
      chk("cnt full", r, 4);
      chk("ovf after fill", con_ovf_a, 0);

      cpu_a.w_v = 1; cpu_a.adr = 32'h4; cpu_a.data = 32'h65;
      cpu_a.strobe = 4'h1; con_pop_a = 1;
      nxt();
      clr_a();
      con_pop_a = 0;
      @(negedge clk);
      chk("push+pop rsp", {cpu_a.res_v, cpu_a.res_error}, 2'b10);
      nxt();
      xact_a(1, 0, 32'h4, 0, 0, r, e, lat, f);
      chk("cnt push+pop", r, 4);
      chk("ovf push+pop", con_ovf_a, 0);
      @(negedge clk);
      chk("head 62", con_char_a, 8'h62);
      nxt();
      xact_a(0, 1, 32'h4, 32'h66, 4'h1, r, e, lat, f);
      chk("ovf set", con_ovf_a, 1);
      xact_a(1, 0, 32'h4, 0, 0, r, e, lat, f);
      chk("cnt ovf", r, 4);
      pop_a();
      @(negedge clk);
      chk("head 63", con_char_a, 8'h63);
      nxt();
      pop_a();
      pop_a();
      @(negedge clk);
      chk("head 65", {con_v_a, con_char_a}, {1'b1, 8'h65});
      nxt();

      cpu_a.r_v = 1; cpu_a.adr = 32'h20010;
      mem_a.res_v = 1; mem_a.res = 32'h12345678; mem_a.res_error = 1;
      @(negedge clk);
      chk("miss r fwd", {mem_a.r_v, mem_a.w_v, mem_a.adr},
          {2'b10, 32'h20010});
      chk("miss r res", {cpu_a.res_v, cpu_a.res_error, cpu_a.res},
          {2'b11, 32'h12345678});
      nxt();
      clr_a();
      cpu_a.w_v = 1; cpu_a.adr = 32'h20020; cpu_a.data = 32'hABCD;
      cpu_a.strobe = 4'h3;
      mem_a.res = 0; mem_a.res_error = 0;
      @(negedge clk);
      chk("miss w fwd", {mem_a.w_v, mem_a.r_v, mem_a.data, mem_a.strobe},
          {2'b10, 32'hABCD, 4'h3});
      chk("miss w rsp", cpu_a.res_v, 1);
      nxt();
      clr_a();
      mem_a.res_v = 0;
      chk("proto clean", proto_a, 0);

      cpu_a.r_v = 1; cpu_a.adr = 32'h20010;
      @(negedge clk);
      chk("slow fwd", {mem_a.r_v, cpu_a.res_v}, 2'b10);
      nxt();
      cpu_a.adr = 32'h4;
      @(negedge clk);
      chk("busy no fwd", {mem_a.r_v, cpu_a.res_v}, 2'b00);
      nxt();
      clr_a();
      mem_a.res_v = 1; mem_a.res = 32'hDEAD0001;
      @(negedge clk);
      chk("slow res", {cpu_a.res_v, cpu_a.res}, {1'b1, 32'hDEAD0001});
      chk("proto set", proto_a, 1);
      nxt();
      mem_a.res_v = 0; mem_a.res = 0;

      expc = bc_a;
      xact_a(1, 0, 32'h8, 0, 0, r, e, lat, f);
      chk("cyc a", r, expc);
      chk("cyc a lat", lat, 1);

      xact_a(0, 1, 32'h0, 32'h7, 4'h1, r, e, lat, f);
      chk("exit wr err", e, 0);
      chk("exit state", {exit_v_a, timeout_a, exit_code_a},
          {2'b10, 32'h7});
      xact_a(1, 0, 32'h20000, 0, 0, r, e, lat, f);
      chk("post exit rd", {f, e}, 2'b01);
      chk("post exit lat", lat, 1);
      xact_a(0, 1, 32'h0, 32'h9, 4'h1, r, e, lat, f);
      chk("exit again err", e, 1);
      chk("exit code kept", exit_code_a, 32'h7);
      xact_a(0, 1, 32'h4, 32'h70, 4'h1, r, e, lat, f);
      pop_a();
      @(negedge clk);
      chk("no push after exit", con_v_a, 0);
      nxt();

      rst_b_n = 1;
      g = 0;
      while (bc_b != 10 && g < 100) begin nxt(); g++; end
      cpu_b.r_v = 1; cpu_b.adr = 32'h8;
      @(negedge clk);
      chk("b c10", cpu_b.res_v, 0);
      nxt();
      cpu_b.r_v = 0; cpu_b.adr = 0;
      for (int k = 11; k <= 13; k++) begin
         @(negedge clk);
         if (k < 13)
            chk($sformatf("b c%0d", k), cpu_b.res_v, 0);
         else
            chk("b c13", {cpu_b.res_v, cpu_b.res_error, cpu_b.res},
                {2'b10, 32'd10});
         nxt();
      end

      rst_b_n = 0;
      nxt();
      rst_b_n = 1;
      g = 0;
      while (bc_b != 10 && g < 100) begin nxt(); g++; end
      cpu_b.r_v = 1; cpu_b.adr = 32'h8;
      nxt();
      cpu_b.r_v = 0; cpu_b.adr = 0;
      rst_b_n = 0;
      nxt();
      nxt();
      rst_b_n = 1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (cpu_b.res_v) seen++;
         nxt();
      end
      chk("b flush", seen, 0);

      g = 0;
      while (bc_b != 49 && g < 100) begin nxt(); g++; end
      @(negedge clk);
      chk("b pre timeout", {timeout_b, exit_v_b}, 2'b00);
      nxt();
      @(negedge clk);
      chk("b timeout", {timeout_b, exit_v_b, exit_code_b},
          {2'b11, 32'hFFFFFFFF});
      nxt();

      cpu_b.r_v = 1; cpu_b.adr = 32'h8;
      nxt();
      cpu_b.r_v = 0; cpu_b.adr = 0;
      lat = -1; e = 0;
      for (int k = 1; k <= 6 && lat < 0; k++) begin
         @(negedge clk);
         if (cpu_b.res_v) begin lat = k; e = cpu_b.res_error; end
         nxt();
      end
      chk("b post-exit lat", lat, 3);
      chk("b post-exit err", e, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
